l2_req_arbiter_2to1: RTL and testbench



---
 rtl/l2_arb_pkg.sv | 14 +
 rtl/l2_resp_id_pipe.sv | 36 +++
 rtl/l2_req_arbiter_2to1.sv | 108 ++++++++++
 tb/tb_l2_req_arbiter_2to1.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and limits for the L2 bank-port 2:1 request arbiter.
// The fixed-priority build is selected by the L2_ARB_FIXED_PRIO_EN macro.
package l2_arb_pkg;

    typedef logic l2_mst_id_t;

    typedef struct packed {
        logic       vld;
        l2_mst_id_t id;
    } l2_resp_slot_t;

    localparam int unsigned MAX_MEM_LATENCY = 8;

endpackage : l2_arb_pkg

// File: rtl/l2_resp_id_pipe.sv
// Fixed-latency shift register that remembers which master owns each
// in-flight bank access so the response can be steered back to it.
module l2_resp_id_pipe
    import l2_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  l2_resp_slot_t slot_i,
    output l2_resp_slot_t slot_o
);

    l2_resp_slot_t [DEPTH-1:0] stage_q;
    l2_resp_slot_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = slot_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset drops every in-flight slot, so pending responses are never issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign slot_o = stage_q[DEPTH-1];

endmodule : l2_resp_id_pipe

// File: rtl/l2_req_arbiter_2to1.sv
// 2:1 round-robin request arbiter in front of one L2 bank port, with
// per-master response steering. Define L2_ARB_FIXED_PRIO_EN for master0 priority.
module l2_req_arbiter_2to1
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req0_i,
    input  logic [ADDR_WIDTH-1:0] data_add0_i,
    input  logic                  data_wen0_i,
    input  logic [DATA_WIDTH-1:0] data_wdata0_i,
    input  logic [BE_WIDTH-1:0]   data_be0_i,
    output logic                  data_gnt0_o,
    input  logic                  data_req1_i,
    input  logic [ADDR_WIDTH-1:0] data_add1_i,
    input  logic                  data_wen1_i,
    input  logic [DATA_WIDTH-1:0] data_wdata1_i,
    input  logic [BE_WIDTH-1:0]   data_be1_i,
    output logic                  data_gnt1_o,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_add_o,
    output logic                  data_wen_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    input  logic                  data_gnt_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    output logic                  data_r_valid0_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata0_o,
    output logic                  data_r_valid1_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata1_o
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
        $error("l2_req_arbiter_2to1: MEM_LATENCY must be within 1..%0d", MAX_MEM_LATENCY);
    end

    l2_mst_id_t    winner;
    logic          hs;
    l2_resp_slot_t slot_in;
    l2_resp_slot_t slot_out;

`ifdef L2_ARB_FIXED_PRIO_EN
    // Master1 only wins when master0 is idle; it may starve under load.
    always_comb begin
        winner = data_req1_i & ~data_req0_i;
    end
`else
    logic prio_q;
    logic prio_d;

    always_comb begin
        winner = data_req1_i;
        if (data_req0_i && data_req1_i) begin
            winner = prio_q;
        end
    end

    // Pure alternation: every handshake hands priority to the other master.
    always_comb begin
        prio_d = prio_q;
        if (hs) begin
            prio_d = ~winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign data_req_o   = data_req0_i | data_req1_i;
    assign data_add_o   = winner ? data_add1_i   : data_add0_i;
    assign data_wen_o   = winner ? data_wen1_i   : data_wen0_i;
    assign data_wdata_o = winner ? data_wdata1_i : data_wdata0_i;
    assign data_be_o    = winner ? data_be1_i    : data_be0_i;

    assign hs          = data_req_o & data_gnt_i;
    assign data_gnt0_o = hs & (winner == 1'b0);
    assign data_gnt1_o = hs & (winner == 1'b1);

    assign slot_in.vld = hs;
    assign slot_in.id  = winner;

    l2_resp_id_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_id_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_i (slot_in),
        .slot_o (slot_out)
    );

    // A single owner id per slot keeps the two response valids mutually exclusive.
    assign data_r_valid0_o = slot_out.vld & (slot_out.id == 1'b0);
    assign data_r_valid1_o = slot_out.vld & (slot_out.id == 1'b1);
    assign data_r_rdata0_o = data_r_rdata_i;
    assign data_r_rdata1_o = data_r_rdata_i;

endmodule : l2_req_arbiter_2to1

// File: tb/tb_l2_req_arbiter_2to1.sv
// Directed self-checking bench for l2_req_arbiter_2to1 (MEM_LATENCY=3).
// Expectations follow L2_ARB_FIXED_PRIO_EN when the macro is defined.
module tb_l2_req_arbiter_2to1;

    localparam int LAT = 3;

    localparam logic [11:0] ADDR0  = 12'h0A5;
    localparam logic [11:0] ADDR1  = 12'h15A;
    localparam logic [63:0] WDATA0 = 64'h0000_1111_2222_3333;
    localparam logic [63:0] WDATA1 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [7:0]  BE0    = 8'h0F;
    localparam logic [7:0]  BE1    = 8'hF0;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, wen0, wen1, gntIn;
    logic        gnt0, gnt1, reqOut, wenOut, rValid0, rValid1;
    logic [11:0] addOut;
    logic [63:0] wdataOut, rdataIn, rdata0, rdata1;
    logic [7:0]  beOut;

    int totalChecks = 0;
    int badChecks   = 0;

    l2_req_arbiter_2to1 #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (64),
        .BE_WIDTH    (8),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_req0_i     (req0),
        .data_add0_i     (ADDR0),
        .data_wen0_i     (wen0),
        .data_wdata0_i   (WDATA0),
        .data_be0_i      (BE0),
        .data_gnt0_o     (gnt0),
        .data_req1_i     (req1),
        .data_add1_i     (ADDR1),
        .data_wen1_i     (wen1),
        .data_wdata1_i   (WDATA1),
        .data_be1_i      (BE1),
        .data_gnt1_o     (gnt1),
        .data_req_o      (reqOut),
        .data_add_o      (addOut),
        .data_wen_o      (wenOut),
        .data_wdata_o    (wdataOut),
        .data_be_o       (beOut),
        .data_gnt_i      (gntIn),
        .data_r_rdata_i  (rdataIn),
        .data_r_valid0_o (rValid0),
        .data_r_rdata0_o (rdata0),
        .data_r_valid1_o (rValid1),
        .data_r_rdata1_o (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r0, input logic r1, input logic g,
                                 input logic w0, input logic w1);
        @(negedge clk);
        req0  = r0;
        req1  = r1;
        gntIn = g;
        wen0  = w0;
        wen1  = w1;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic eg0, input logic eg1,
                              input logic erv0, input logic erv1);
        checkOutput({tag, ".gnt0"}, 64'(gnt0), 64'(eg0));
        checkOutput({tag, ".gnt1"}, 64'(gnt1), 64'(eg1));
        checkOutput({tag, ".rvalid0"}, 64'(rValid0), 64'(erv0));
        checkOutput({tag, ".rvalid1"}, 64'(rValid1), 64'(erv1));
        checkOutput({tag, ".excl"}, 64'(rValid0 & rValid1), 64'd0);
    endtask

    task automatic checkMux(input string tag, input int w);
        checkOutput({tag, ".add"},   64'(addOut),  (w == 0) ? 64'(ADDR0) : 64'(ADDR1));
        checkOutput({tag, ".wdata"}, wdataOut,     (w == 0) ? WDATA0 : WDATA1);
        checkOutput({tag, ".be"},    64'(beOut),   (w == 0) ? 64'(BE0) : 64'(BE1));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        gntIn = 1'b0;
        #1;
        checkOutput("reset.rvalid0", 64'(rValid0), 64'd0);
        checkOutput("reset.rvalid1", 64'(rValid1), 64'd0);
        checkOutput("reset.req_o",   64'(reqOut),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int winAt(input int j);
`ifdef L2_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (j - 1) % 2;
`endif
    endfunction

    initial begin
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        wen0    = 1'b1;
        wen1    = 1'b1;
        gntIn   = 1'b0;
        rdataIn = 64'd0;

        // Test 1: master0 alone for 4 cycles
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(i <= 4, 1'b0, 1'b1, 1'b1, 1'b1);
            checkCycle($sformatf("single.c%0d", i), i <= 4, 1'b0,
                       (i >= 1 + LAT) && (i <= 4 + LAT), 1'b0);
            if (i <= 4) checkMux($sformatf("single.c%0d", i), 0);
        end

        // Test 2: contention after reset
        doReset();
        for (int i = 1; i <= 8; i++) begin
            int w;
            int wr;
            logic rv;
            w  = winAt(i);
            wr = winAt(i - LAT);
            rv = (i >= 1 + LAT) && (i <= 4 + LAT);
            applyStimulus(i <= 4, i <= 4, 1'b1, 1'b1, 1'b1);
            checkCycle($sformatf("contend.c%0d", i),
                       (i <= 4) && (w == 0), (i <= 4) && (w == 1),
                       rv && (wr == 0), rv && (wr == 1));
            if (i <= 4) checkMux($sformatf("contend.c%0d", i), w);
        end

        // Test 3: bank stall, pointer must hold while gnt_i is low
        doReset();
        for (int i = 1; i <= 10; i++) begin
            logic r0;
            logic r1;
            r0 = (i == 4) || (i == 5);
            r1 = (i <= 6);
            applyStimulus(r0, r1, i == 6, 1'b1, 1'b1);
            checkCycle($sformatf("stall.c%0d", i), 1'b0, i == 6, 1'b0, i == 6 + LAT);
            if (i <= 3 || i == 6) checkMux($sformatf("stall.c%0d", i), 1);
            if (i == 4 || i == 5) checkMux($sformatf("stall.c%0d", i), 0);
            if (i <= 6) checkOutput($sformatf("stall.c%0d.req_o", i), 64'(reqOut), 64'd1);
        end

        // Test 4: write by master0 in cycle 5, read by master1 in cycle 6
        doReset();
        for (int i = 1; i <= 10; i++) begin
            rdataIn = (i == 9) ? 64'hDEAD_BEEF_0123_4567 : 64'h0;
            applyStimulus(i == 5, i == 6, 1'b1, 1'b0, 1'b1);
            checkCycle($sformatf("wr_rd.c%0d", i), i == 5, i == 6, i == 8, i == 9);
            if (i == 5) checkOutput("wr_rd.c5.wen_o", 64'(wenOut), 64'd0);
            if (i == 6) checkOutput("wr_rd.c6.wen_o", 64'(wenOut), 64'd1);
            if (i == 9) checkOutput("wr_rd.c9.rdata1", rdata1, 64'hDEAD_BEEF_0123_4567);
        end

        // Test 5: reset one cycle after two master0 handshakes
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCycle("midrst.c1", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCycle("midrst.c2", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        gntIn = 1'b0;
        #1;
        checkCycle("midrst.c3", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            rst_n = 1'b1;
            checkCycle($sformatf("midrst.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkCycle("midrst.c8", 1'b1, 1'b0, 1'b0, 1'b0);
        checkMux("midrst.c8", 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule : tb_l2_req_arbiter_2to1
